// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: one multiplier and one accumulator iterated over TAPS cycles per sample.
// Samples, coefficients and the output are sign-magnitude Q1.(DATA_W-1); coefficients load at
// run time through a write port that is only open while the block is idle.
// Build option: define FIR_SAT_EN to clamp the output magnitude instead of wrapping it.
module fir_serial_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 30,
    parameter int unsigned AW     = $clog2(TAPS)
) (
    input  logic              clk_slow_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              coef_wr_en_i,
    input  logic [AW-1:0]     coef_addr_i,
    input  logic [DATA_W-1:0] coef_data_i,
    output logic              coef_wr_err_o,
    output logic [DATA_W-1:0] fir_out_o,
    output logic              out_valid_o
);

    localparam int unsigned MagW  = DATA_W - 1;
    localparam int unsigned ProdW = 2 * MagW;
    localparam int unsigned AccW  = ProdW + AW + 1;

    localparam logic [AW:0]   TapsL = (AW+1)'(TAPS);
    localparam logic [AW-1:0] LastK = AW'(TAPS - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       k_q, k_d;
    logic [AW-1:0]       wp_q, wp_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]   fir_out_q, fir_out_d;
    logic                out_valid_q, out_valid_d;
    logic                coef_wr_err_q, coef_wr_err_d;

    logic [DATA_W-1:0]   hist_q [TAPS];
    logic [DATA_W-1:0]   coef_q [TAPS];

    logic [AW-1:0]       rd_idx;
    logic [DATA_W-1:0]   x_op, c_op;
    logic [ProdW-1:0]    prod_mag;
    logic [AccW-1:0]     prod_ext, prod_tc, acc_sum, acc_abs;
    logic                acc_neg;
    logic [MagW-1:0]     out_mag;
    logic [DATA_W-1:0]   out_word;
    logic                unused_acc_bits;

    logic                accept;
    logic                coef_we;

    assign accept  = (state_q == StIdle) && in_valid_i;
    assign coef_we = (state_q == StIdle) && coef_wr_en_i && ({1'b0, coef_addr_i} < TapsL);

    // Datapath: tap product, running sum and conversion back to sign-magnitude.
    always_comb begin
        // History index wp-k modulo TAPS; the newest sample sits at wp during ACCUM.
        rd_idx = (wp_q >= k_q) ? (wp_q - k_q)
                               : AW'(TapsL + {1'b0, wp_q} - {1'b0, k_q});
        x_op     = hist_q[rd_idx];
        c_op     = coef_q[k_q];
        prod_mag = ProdW'(x_op[MagW-1:0]) * ProdW'(c_op[MagW-1:0]);
        prod_ext = {{(AccW-ProdW){1'b0}}, prod_mag};
        // A -0 operand gives a zero magnitude, so its negation is still zero.
        prod_tc  = (x_op[MagW] ^ c_op[MagW]) ? (~prod_ext + 1'b1) : prod_ext;
        acc_sum  = acc_q + prod_tc;
        acc_neg  = acc_sum[AccW-1];
        acc_abs  = acc_neg ? (~acc_sum + 1'b1) : acc_sum;
`ifdef FIR_SAT_EN
        out_mag         = (|acc_abs[AccW-1:ProdW]) ? {MagW{1'b1}} : acc_abs[ProdW-1:MagW];
        unused_acc_bits = ^acc_abs[MagW-1:0];
`else
        out_mag         = acc_abs[ProdW-1:MagW];
        unused_acc_bits = ^{acc_abs[AccW-1:ProdW], acc_abs[MagW-1:0]};
`endif
        // Never emit -0.
        out_word = {acc_neg & (|out_mag), out_mag};
    end

    // Next-state logic for the IDLE -> ACCUM -> DONE sequence.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        wp_d          = wp_q;
        acc_d         = acc_q;
        fir_out_d     = fir_out_q;
        out_valid_d   = 1'b0;
        coef_wr_err_d = coef_wr_en_i && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (k_q == LastK) begin
                    // Result is registered on the way into DONE so it is visible during DONE.
                    k_d         = '0;
                    wp_d        = (wp_q == LastK) ? '0 : wp_q + 1'b1;
                    fir_out_d   = out_word;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_slow_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            k_q           <= '0;
            wp_q          <= '0;
            acc_q         <= '0;
            fir_out_q     <= '0;
            out_valid_q   <= 1'b0;
            coef_wr_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            wp_q          <= wp_d;
            acc_q         <= acc_d;
            fir_out_q     <= fir_out_d;
            out_valid_q   <= out_valid_d;
            coef_wr_err_q <= coef_wr_err_d;
        end
    end

    // Sample history and coefficient store; a same-cycle coefficient write lands before ACCUM.
    always_ff @(posedge clk_slow_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                hist_q[wp_q] <= in_data_i;
            end
            if (coef_we) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign coef_wr_err_o = coef_wr_err_q;
    assign fir_out_o     = fir_out_q;
    assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac with a reference model computing y[n] = sum c[k]*x[n-k] in plain
// integer arithmetic. Define FIR_SAT_EN for both bench and RTL to exercise the clamping build.
module tb_fir_serial_mac;

    localparam int DW   = 16;
    localparam int TAPS = 30;
    localparam int AW   = 5;
    localparam longint Scale = 64'sd1 << (DW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          coef_wr_en = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [DW-1:0] coef_data = '0;
    logic          coef_wr_err;
    logic [DW-1:0] fir_out;
    logic          out_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: coefficients by tap, history with the newest sample at index 0.
    logic [DW-1:0] mc [TAPS];
    logic [DW-1:0] mh [TAPS];

    fir_serial_mac #(
        .DATA_W (DW),
        .TAPS   (TAPS),
        .AW     (AW)
    ) dut (
        .clk_slow_i    (clk),
        .rst_ni        (rst_n),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .coef_wr_en_i  (coef_wr_en),
        .coef_addr_i   (coef_addr),
        .coef_data_i   (coef_data),
        .coef_wr_err_o (coef_wr_err),
        .fir_out_o     (fir_out),
        .out_valid_o   (out_valid)
    );

    always #5 clk = ~clk;

    function automatic longint smv(input logic [DW-1:0] v);
        longint m;
        m = longint'(v[DW-2:0]);
        return v[DW-1] ? -m : m;
    endfunction

    function automatic logic [DW-1:0] ref_out();
        longint s;
        longint a;
        logic [DW-2:0] m;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += smv(mc[k]) * smv(mh[k]);
        a = (s < 0) ? -s : s;
        a = a / Scale;
`ifdef FIR_SAT_EN
        if (a > Scale - 1) a = Scale - 1;
`else
        a = a % Scale;
`endif
        m = a[DW-2:0];
        return {(s < 0) && (m != 0), m};
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            mc[k] = '0;
            mh[k] = '0;
        end
    endfunction

    function automatic void model_push(input logic [DW-1:0] x);
        for (int k = TAPS - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready in_ready=%b still low after %0d cycles, want 1", in_ready, n);
        end
    endtask

    task automatic wr_coef(input int k, input logic [DW-1:0] v);
        wait_ready();
        coef_wr_en = 1'b1;
        coef_addr  = AW'(k);
        coef_data  = v;
        tick();
        coef_wr_en = 1'b0;
        if (k < TAPS) mc[k] = v;
    endtask

    // Offer one sample (optionally with a same-cycle coefficient write), wait for its result and
    // return to IDLE. lat counts cycles from the accept to the out_valid pulse.
    task automatic send(input logic [DW-1:0] x, input bit do_wr, input int wr_k,
                        input logic [DW-1:0] wr_v, output logic [DW-1:0] y, output int lat);
        wait_ready();
        in_data  = x;
        in_valid = 1'b1;
        if (do_wr) begin
            coef_wr_en = 1'b1;
            coef_addr  = AW'(wr_k);
            coef_data  = wr_v;
        end
        tick();
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        if (do_wr && wr_k < TAPS) mc[wr_k] = wr_v;
        model_push(x);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        y = fir_out;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks += 4;
        if (fir_out !== 16'h0000) begin
            n_errors++; $display("FAIL reset_fir_out got %h want 0000", fir_out);
        end
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        if (coef_wr_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_coef_wr_err got %b want 0", coef_wr_err);
        end
        rst_n = 1'b1;
        model_clear();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] y;
        int lat;
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'(16'h0040 * k));
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 16'h7FFF : 16'h0000, 1'b0, 0, 16'h0, y, lat);
            n_checks += 2;
            if (y !== ref_out()) begin
                n_errors++; $display("FAIL impulse[%0d] fir_out got %h want %h", n, y, ref_out());
            end
            if (lat != TAPS + 1) begin
                n_errors++; $display("FAIL impulse_lat[%0d] got %0d want %0d", n, lat, TAPS + 1);
            end
        end
    endtask

    task automatic test_sign();
        logic [DW-1:0] y;
        int lat;
        for (int k = 0; k < TAPS; k++) wr_coef(k, (k == 0) ? 16'hC000 : 16'h0000);
        send(16'h4000, 1'b0, 0, 16'h0, y, lat);
        n_checks += 2;
        if (y !== 16'hA000) begin
            n_errors++; $display("FAIL sign_neg got %h want A000", y);
        end
        if (y !== ref_out()) begin
            n_errors++; $display("FAIL sign_neg_model got %h want %h", y, ref_out());
        end
        send(16'h0000, 1'b0, 0, 16'h0, y, lat);
        n_checks++;
        if (y !== 16'h0000) begin
            n_errors++; $display("FAIL sign_zero got %h want 0000", y);
        end
    endtask

    task automatic test_cancel();
        logic [DW-1:0] y;
        int lat;
        wr_coef(0, 16'h4000);
        wr_coef(1, 16'hC000);
        send(16'h4000, 1'b0, 0, 16'h0, y, lat);
        n_checks++;
        if (y !== 16'h2000) begin
            n_errors++; $display("FAIL cancel_first got %h want 2000", y);
        end
        send(16'h4000, 1'b0, 0, 16'h0, y, lat);
        n_checks++;
        if (y !== 16'h0000) begin
            n_errors++; $display("FAIL cancel_second got %h want 0000", y);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] y;
        logic [DW-1:0] want_last;
        int lat;
`ifdef FIR_SAT_EN
        want_last = 16'h7FFF;
`else
        want_last = 16'h7FC4;
`endif
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'h7FFF);
        for (int n = 0; n < TAPS; n++) begin
            send(16'h7FFF, 1'b0, 0, 16'h0, y, lat);
            n_checks++;
            if (y !== ref_out()) begin
                n_errors++; $display("FAIL overflow[%0d] got %h want %h", n, y, ref_out());
            end
        end
        n_checks++;
        if (y !== want_last) begin
            n_errors++; $display("FAIL overflow_last got %h want %h", y, want_last);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] want;
        int errs;
        int outs;
        bit took;
        errs = 0;
        outs = 0;
        wait_ready();
        in_data  = 16'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (out_valid === 1'b1) begin
                outs++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                n_checks++;
                if (fir_out !== want) begin
                    n_errors++; $display("FAIL b2b_out[%0d] got %h want %h", outs, fir_out, want);
                end
            end
            if (coef_wr_err === 1'b1) errs++;
            coef_wr_en = 1'b0;
            took = in_valid && (in_ready === 1'b1);
            if (took) begin
                acc_cyc.push_back(c);
                model_push(in_data);
                exp_q.push_back(ref_out());
            end
            if (acc_cyc.size() == 1 && c == acc_cyc[0] + 5) begin
                coef_wr_en = 1'b1;
                coef_addr  = '0;
                coef_data  = 16'h0001;
            end
            tick();
            if (acc_cyc.size() == 3) in_valid = 1'b0;
            else if (took) in_data = 16'($urandom);
        end
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        n_checks += 3;
        if (acc_cyc.size() != 3) begin
            n_errors++; $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size());
        end else begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != TAPS + 2 || acc_cyc[2] - acc_cyc[1] != TAPS + 2) begin
                n_errors++;
                $display("FAIL b2b_spacing got %0d,%0d want %0d", acc_cyc[1] - acc_cyc[0],
                         acc_cyc[2] - acc_cyc[1], TAPS + 2);
            end
        end
        if (errs != 1) begin
            n_errors++; $display("FAIL b2b_coef_wr_err pulses got %0d want 1", errs);
        end
        if (outs != 3) begin
            n_errors++; $display("FAIL b2b_outputs got %0d want 3", outs);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] y;
        logic [DW-1:0] x;
        logic [DW-1:0] v;
        int lat;
        int k;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(31);
            v = 16'($urandom);
            if ($urandom_range(7) == 0) v = 16'h8000;
            wr_coef(k, v);
        end
        for (int i = 0; i < 12; i++) begin
            x = 16'($urandom);
            if ($urandom_range(5) == 0) x = 16'h8000;
            k = $urandom_range(TAPS - 1);
            v = 16'($urandom);
            send(x, (i % 4) == 1, k, v, y, lat);
            n_checks += 2;
            if (y !== ref_out()) begin
                n_errors++; $display("FAIL random[%0d] got %h want %h", i, y, ref_out());
            end
            if (lat != TAPS + 1) begin
                n_errors++; $display("FAIL random_lat[%0d] got %0d want %0d", i, lat, TAPS + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] y;
        int lat;
        int stray;
        wait_ready();
        in_data  = 16'h7FFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (fir_out !== 16'h0000) begin
            n_errors++; $display("FAIL midrst_fir_out got %h want 0000", fir_out);
        end
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready);
        end
        stray = 0;
        repeat (3) begin
            tick();
            if (out_valid === 1'b1) stray++;
        end
        rst_n = 1'b1;
        model_clear();
        repeat (TAPS + 5) begin
            tick();
            if (out_valid === 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++; $display("FAIL midrst_stray_valid got %0d pulses want 0", stray);
        end
        for (int n = 0; n < 5; n++) begin
            send((n == 0) ? 16'h7FFF : 16'h0000, 1'b0, 0, 16'h0, y, lat);
            n_checks++;
            if (y !== 16'h0000 || y !== ref_out()) begin
                n_errors++; $display("FAIL midrst_impulse[%0d] got %h want 0000", n, y);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_sign();
        test_cancel();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
